// File: rtl/fusion_mac_ctrl_pkg.sv
// Shared definitions for the fusion MAC controller.
//   state_e      : controller states (IDLE, RUN, DRAIN, DONE)
//   WIDTH_*      : legal operand widths
//   OPND_W       : raw operand port width
//   PROD_W       : fusion_unit product width
//   width_legal  : 1 when a width code is one of the legal widths
//   width_mask   : keep-mask for the low <width> bits of an operand
package fusion_mac_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [3:0] WIDTH_1 = 4'd1;
  localparam logic [3:0] WIDTH_2 = 4'd2;
  localparam logic [3:0] WIDTH_4 = 4'd4;
  localparam logic [3:0] WIDTH_8 = 4'd8;

  localparam int OPND_W = 8;
  localparam int PROD_W = 16;

  function automatic logic width_legal(input logic [3:0] w);
    return (w == WIDTH_1) || (w == WIDTH_2) || (w == WIDTH_4) || (w == WIDTH_8);
  endfunction

  function automatic logic [OPND_W-1:0] width_mask(input logic [3:0] w);
    logic [OPND_W-1:0] m;
    case (w)
      WIDTH_1: m = 8'h01;
      WIDTH_2: m = 8'h03;
      WIDTH_4: m = 8'h0F;
      WIDTH_8: m = 8'hFF;
      default: m = 8'h00;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/fusion_mac_ctrl_fusion_unit.sv
// fusion_unit: variable-precision multiplier.
//   in_i, wt_i          : operands, already masked to their widths
//   in_width_i/wt_width_i: operand widths (1, 2, 4 or 8)
//   s_in_i/s_wt_i       : operand signedness
//   prod_o              : 16-bit two's complement (or unsigned) product
// Each operand is widened to 9-bit signed from its own width, so a signed
// 1-bit value of 1 means -1 and an unsigned 8-bit 255 stays +255.
module fusion_unit
  import fusion_mac_ctrl_pkg::*;
(
  input  logic [OPND_W-1:0] in_i,
  input  logic [OPND_W-1:0] wt_i,
  input  logic [3:0]        in_width_i,
  input  logic [3:0]        wt_width_i,
  input  logic              s_in_i,
  input  logic              s_wt_i,
  output logic [PROD_W-1:0] prod_o
);

  function automatic logic signed [OPND_W:0] ext_opnd(input logic [OPND_W-1:0] x,
                                                      input logic [3:0]        w,
                                                      input logic              s);
    logic [OPND_W-1:0] m;
    logic [OPND_W-1:0] top;
    logic              neg;
    m   = width_mask(w);
    top = m & ~(m >> 1);               // single bit at position width-1
    neg = s & (|(x & top));
    return neg ? {1'b1, x | ~m} : {1'b0, x};
  endfunction

  logic signed [OPND_W:0]   in_ext;
  logic signed [OPND_W:0]   wt_ext;
  logic signed [PROD_W-1:0] in_16;
  logic signed [PROD_W-1:0] wt_16;
  logic signed [PROD_W-1:0] prod_s;

  assign in_ext = ext_opnd(in_i, in_width_i, s_in_i);
  assign wt_ext = ext_opnd(wt_i, wt_width_i, s_wt_i);
  assign in_16  = PROD_W'(in_ext);
  assign wt_16  = PROD_W'(wt_ext);
  // Any legal product fits in 16 bits, so the low half is exact.
  assign prod_s = in_16 * wt_16;
  assign prod_o = prod_s;

endmodule

// File: rtl/fusion_mac_ctrl.sv
// fusion_mac_ctrl: streaming dot-product controller around one fusion_unit.
//   clk, rst_n          : clock, asynchronous active-low reset
//   start, cfg_*        : job request and configuration (sampled in IDLE)
//   op_valid/op_ready   : operand-pair stream handshake, op_in/op_weight data
//   res_valid/res_ready : result handshake, res_data accumulated sum
//   busy                : high outside IDLE
//   cfg_err             : one-cycle pulse when start carries an illegal width
module fusion_mac_ctrl
  import fusion_mac_ctrl_pkg::*;
#(
  parameter int LEN_W = 8,
  parameter int ACC_W = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [3:0]        cfg_in_width,
  input  logic [3:0]        cfg_weight_width,
  input  logic              cfg_s_in,
  input  logic              cfg_s_weight,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [OPND_W-1:0] op_in,
  input  logic [OPND_W-1:0] op_weight,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ACC_W-1:0]  res_data,
  output logic              busy,
  output logic              cfg_err
);

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   count_q, len_q;
  logic [3:0]         in_w_q, wt_w_q;
  logic               s_in_q, s_wt_q;
  logic [OPND_W-1:0]  in_p0_q, wt_p0_q;
  logic               vld_p0_q;
  logic signed [ACC_W-1:0] acc_q;
  logic               cfg_err_q;

  logic               legal, accept, reject, xfer;
  logic [PROD_W-1:0]  prod;
  logic signed [ACC_W-1:0] prod_ext;

  assign legal  = width_legal(cfg_in_width) && width_legal(cfg_weight_width);
  assign accept = (state_q == S_IDLE) && start && legal;
  assign reject = (state_q == S_IDLE) && start && !legal;
  assign xfer   = op_valid && op_ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = (cfg_len == '0) ? S_DONE : S_RUN;
      S_RUN:   if (xfer && (count_q == len_q - LEN_W'(1))) state_d = S_DRAIN;
      S_DRAIN: state_d = S_DONE;
      S_DONE:  if (res_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Stage p0 -> accumulator: multiply the registered pair, extend, add.
  fusion_unit u_fusion (
    .in_i       (in_p0_q),
    .wt_i       (wt_p0_q),
    .in_width_i (in_w_q),
    .wt_width_i (wt_w_q),
    .s_in_i     (s_in_q),
    .s_wt_i     (s_wt_q),
    .prod_o     (prod)
  );

  assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1] & (s_in_q | s_wt_q)}}, prod};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      len_q     <= '0;
      in_w_q    <= '0;
      wt_w_q    <= '0;
      s_in_q    <= 1'b0;
      s_wt_q    <= 1'b0;
      in_p0_q   <= '0;
      wt_p0_q   <= '0;
      vld_p0_q  <= 1'b0;
      acc_q     <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cfg_err_q <= reject;
      if (accept) begin
        len_q   <= cfg_len;
        in_w_q  <= cfg_in_width;
        wt_w_q  <= cfg_weight_width;
        s_in_q  <= cfg_s_in;
        s_wt_q  <= cfg_s_weight;
        count_q <= '0;
      end else if (xfer) begin
        count_q <= count_q + LEN_W'(1);
      end
      // Input stage: capture the transferred pair with high bits cleared.
      vld_p0_q <= xfer;
      if (xfer) begin
        in_p0_q <= op_in & width_mask(in_w_q);
        wt_p0_q <= op_weight & width_mask(wt_w_q);
      end
      // Accumulate stage: the pair captured last cycle lands here.
      if (accept)        acc_q <= '0;
      else if (vld_p0_q) acc_q <= acc_q + prod_ext;
    end
  end

  assign op_ready  = (state_q == S_RUN) && (count_q < len_q);
  assign res_valid = (state_q == S_DONE);
  assign res_data  = acc_q;
  assign busy      = (state_q != S_IDLE);
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_fusion_mac_ctrl.sv
module tb_fusion_mac_ctrl;

  localparam int LEN_W = 8;
  localparam int ACC_W = 24;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [3:0]       cfg_in_width, cfg_weight_width;
  logic             cfg_s_in, cfg_s_weight;
  logic [LEN_W-1:0] cfg_len;
  logic             op_valid, op_ready;
  logic [7:0]       op_in, op_weight;
  logic             res_valid, res_ready;
  logic [ACC_W-1:0] res_data;
  logic             busy, cfg_err;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] vin [256];
  logic [7:0] vwt [256];

  fusion_mac_ctrl #(.LEN_W(LEN_W), .ACC_W(ACC_W)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .cfg_in_width     (cfg_in_width),
    .cfg_weight_width (cfg_weight_width),
    .cfg_s_in         (cfg_s_in),
    .cfg_s_weight     (cfg_s_weight),
    .cfg_len          (cfg_len),
    .op_valid         (op_valid),
    .op_ready         (op_ready),
    .op_in            (op_in),
    .op_weight        (op_weight),
    .res_valid        (res_valid),
    .res_ready        (res_ready),
    .res_data         (res_data),
    .busy             (busy),
    .cfg_err          (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Value of an operand as the arithmetic sees it: low w bits, optionally signed.
  function automatic longint opval(input logic [7:0] x, input int w, input bit s);
    longint v;
    v = longint'(x) % (longint'(1) << w);
    if (s && v >= (longint'(1) << (w - 1))) v = v - (longint'(1) << w);
    return v;
  endfunction

  // Dot product of the first len pairs, reduced modulo 2^ACC_W.
  function automatic logic [31:0] model(input int len, input int iw, input int ww,
                                        input bit si, input bit sw);
    longint acc;
    acc = 0;
    for (int i = 0; i < len; i++) acc += opval(vin[i], iw, si) * opval(vwt[i], ww, sw);
    return 32'(acc & ((longint'(1) << ACC_W) - 1));
  endfunction

  task automatic run_vec(input string tag, input int iw, input int ww, input bit si,
                         input bit sw, input int len, input int stall_pct,
                         input int stall_at, input int stall_n, input int rdy_dly,
                         input longint lit);
    logic [31:0] exp;
    int idx, stalls, forced, cyc, exp_lat;
    exp = model(len, iw, ww, si, sw);
    cfg_in_width = 4'(iw); cfg_weight_width = 4'(ww);
    cfg_s_in = si; cfg_s_weight = sw; cfg_len = LEN_W'(len);
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1; idx = 0; stalls = 0; forced = 0;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    while (!res_valid && cyc < 3000) begin
      // Junk on start/config while busy must not disturb the job.
      start = 1'($urandom_range(0, 1));
      cfg_len = LEN_W'($urandom);
      cfg_in_width = 4'($urandom);
      cfg_s_in = 1'($urandom);
      op_in = 8'($urandom); op_weight = 8'($urandom);
      if (op_ready) begin
        if (idx == stall_at && forced < stall_n) begin
          op_valid = 1'b0; stalls++; forced++;
        end else if (int'($urandom_range(0, 99)) < stall_pct) begin
          op_valid = 1'b0; stalls++;
        end else begin
          op_valid = 1'b1; op_in = vin[idx]; op_weight = vwt[idx]; idx++;
        end
      end else begin
        op_valid = 1'($urandom_range(0, 1));
      end
      tick();
      cyc++;
    end
    start = 1'b0; op_valid = 1'b0;
    exp_lat = (len == 0) ? 1 : len + 2 + stalls;
    chk({tag, "_valid"}, 32'(res_valid), 32'd1);
    chk({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
    chk({tag, "_data"}, 32'(res_data), exp);
    if (lit >= 0) chk({tag, "_literal"}, 32'(res_data), 32'(lit));
    res_ready = 1'b0;
    repeat (rdy_dly) tick();
    chk({tag, "_hold_valid"}, 32'(res_valid), 32'd1);
    chk({tag, "_hold_data"}, 32'(res_data), exp);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    chk({tag, "_idle_valid"}, 32'(res_valid), 32'd0);
  endtask

  initial begin
    int iw, ww, len;
    rst_n = 1'b0; start = 1'b0; cfg_in_width = '0; cfg_weight_width = '0;
    cfg_s_in = 1'b0; cfg_s_weight = 1'b0; cfg_len = '0;
    op_valid = 1'b0; op_in = '0; op_weight = '0; res_ready = 1'b0;
    repeat (2) tick();
    chk("rst_op_ready", 32'(op_ready), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_data", 32'(res_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cfg_err", 32'(cfg_err), 32'd0);
    rst_n = 1'b1;

    // Unsigned 8x8, three pairs, no stalls
    vin[0] = 8'd255; vwt[0] = 8'd255;
    vin[1] = 8'd1;   vwt[1] = 8'd2;
    vin[2] = 8'd0;   vwt[2] = 8'd7;
    run_vec("u8x8", 8, 8, 1'b0, 1'b0, 3, 0, -1, 0, 0, 65027);

    // Width masking 4x2
    vin[0] = 8'hFB; vwt[0] = 8'hFF;
    vin[1] = 8'hFB; vwt[1] = 8'hFF;
    run_vec("mask4x2", 4, 2, 1'b0, 1'b0, 2, 0, -1, 0, 1, 66);

    // Signed 4x4: -5 * 6, with junk above the width
    vin[0] = 8'hAB; vwt[0] = 8'hC6;
    run_vec("s4x4", 4, 4, 1'b1, 1'b1, 1, 0, -1, 0, 0, 24'hFFFFE2);

    // Illegal width rejected
    cfg_in_width = 4'd3; cfg_weight_width = 4'd8; cfg_len = 8'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("cfg_err_pulse", 32'(cfg_err), 32'd1);
    chk("cfg_err_busy", 32'(busy), 32'd0);
    tick();
    chk("cfg_err_drop", 32'(cfg_err), 32'd0);
    chk("cfg_err_still_idle", 32'(busy), 32'd0);

    // Zero-length vector
    run_vec("len0", 8, 8, 1'b0, 1'b0, 0, 0, -1, 0, 0, 0);

    // Forced 3-cycle stall mid-vector and 4 cycles of result backpressure
    for (int i = 0; i < 6; i++) begin vin[i] = 8'($urandom); vwt[i] = 8'($urandom); end
    run_vec("stall", 8, 8, 1'b1, 1'b0, 6, 0, 2, 3, 4, -1);

    // Reset after 2 of 4 pairs, then a fresh single pair
    cfg_in_width = 4'd8; cfg_weight_width = 4'd8; cfg_s_in = 1'b0; cfg_s_weight = 1'b0;
    cfg_len = 8'd4; start = 1'b1;
    tick();
    start = 1'b0; op_valid = 1'b1; op_in = 8'd50; op_weight = 8'd60;
    repeat (2) tick();
    op_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_op_ready", 32'(op_ready), 32'd0);
    chk("midrst_res_data", 32'(res_data), 32'd0);
    chk("midrst_res_valid", 32'(res_valid), 32'd0);
    tick();
    rst_n = 1'b1;
    vin[0] = 8'd3; vwt[0] = 8'd3;
    run_vec("after_rst", 8, 8, 1'b0, 1'b0, 1, 0, -1, 0, 0, 9);

    // Random jobs
    for (int t = 0; t < 25; t++) begin
      case ($urandom_range(0, 3)) 0: iw = 1; 1: iw = 2; 2: iw = 4; default: iw = 8; endcase
      case ($urandom_range(0, 3)) 0: ww = 1; 1: ww = 2; 2: ww = 4; default: ww = 8; endcase
      len = (t == 24) ? 255 : int'($urandom_range(0, 20));
      for (int i = 0; i < len; i++) begin vin[i] = 8'($urandom); vwt[i] = 8'($urandom); end
      run_vec($sformatf("rand%0d", t), iw, ww, 1'($urandom), 1'($urandom), len, 25, -1, 0,
              int'($urandom_range(0, 3)), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
